serdesphy_csr_ctrl: RTL
=======================

Name: serdesphy_csr_ctrl

Overview:
Register-file controller behind the I2C slave in the SerDes PHY CSR path. Arbitrates single-cycle register writes between I2C write strobes and on-chip hardware status/interrupt requesters. Owns a fixed 4-register map (CTRL, CFG, STATUS, IRQ) and sequences a commit handshake that transfers the shadow CFG value into the PHY's active configuration. Returns the flattened register image to the I2C slave's read path.

Parameters:
NUM_HW, 2, number of hardware status requesters (1..4)
APPLY_TIMEOUT, 255, clk cycles to wait for cfg_ack before flagging an error (1..65535)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
i2c_wr_strobe  in  1  one-cycle I2C write pulse; cannot be back-pressured
i2c_wr_addr  in  8  I2C target register index
i2c_wr_data  in  8  I2C write data
hw_req  in  NUM_HW  per-requester write request; held high until granted
hw_sel  in  NUM_HW  per-requester target: 0 = STATUS overwrite, 1 = IRQ set-bits
hw_data  in  NUM_HW*8  per-requester data, requester k at [k*8 +: 8]
hw_gnt  out  NUM_HW  one-hot, one-cycle grant; the write takes effect on that same edge
regs_rd  out  32  {IRQ, STATUS_view, CFG, CTRL_view} to the I2C slave regs_in
cfg_active  out  8  configuration applied to the PHY
cfg_req  out  1  commit request level, held until acknowledged or timed out
cfg_ack  in  1  PHY acknowledge, synchronous to clk
commit_busy  out  1  high while the commit FSM is not IDLE
irq  out  1  OR of IRQ & {1'b1, CTRL[7:1]}

Behaviour:
- Reset values: CTRL=0, CFG=0, STATUS=0, IRQ=0, cfg_active=0, cfg_req=0, hw_gnt=0, FSM=IDLE, RR pointer=0.
- Register map:
  - 0 CTRL: RW. Bit0 COMMIT is self-clearing and always reads 0. Bits 7:1 are IRQ enables for IRQ[6:0].
  - 1 CFG: RW shadow.
  - 2 STATUS: read-only from I2C; HW overwrites it. The read view replaces bit7 with commit_busy.
  - 3 IRQ: I2C write-1-to-clear; HW sets bits by OR.
- I2C writes to index >=4 or to STATUS are ignored with no side effects.
- Arbitration:
  - An I2C strobe always wins its cycle; no hw_gnt is issued in that cycle.
  - Otherwise, round-robin among the asserted hw_req, starting at the RR pointer. After a grant to k, pointer = (k+1) mod NUM_HW.
  - At most one hw_gnt per cycle. Grant is combinational from the registered req, and the write commits on the same clock edge.
- Same-cycle IRQ conflict: new IRQ = (IRQ & ~clear_mask) | set_mask. The HW set is accepted only if granted; an I2C cycle blocks grants. Internal timeout set-bits are never blocked, and set beats clear on the same bit.
- Commit FSM:
  - IDLE: an I2C write to CTRL with data[0]=1 → REQ next cycle. cfg_req=1, cfg_active latched from CFG (including a CFG value written in that same... n/a, CFG is a separate write).
  - REQ: counter increments each cycle.
    - cfg_ack=1 → DONE.
    - Counter reaches APPLY_TIMEOUT → set IRQ[7], drop cfg_req, → IDLE.
  - DONE: cfg_req=0 for one cycle → IDLE. commit_busy=0 only in IDLE.
  - COMMIT while busy: ignored (dropped, not queued). CTRL bits 7:1 still update.
- CFG writes during REQ modify only the shadow; cfg_active stays stable until the next commit.
- cfg_ack in IDLE or DONE is ignored.
- Asynchronous reset mid-commit: cfg_req falls immediately and cfg_active returns to 0.
- The RR pointer advances only on a grant.

Test Plan:
- Reset, then I2C writes 0x5A to index 1 and reads regs_rd → regs_rd[15:8]=0x5A, cfg_active=0x00, cfg_req=0.
- I2C writes 0x01 to CTRL; cfg_ack asserts 3 cycles after cfg_req → cfg_active=0x5A, commit_busy high for exactly 5 cycles, CTRL view reads 0x00.
- cfg_ack tied low, APPLY_TIMEOUT=16, commit → cfg_req drops after 16 REQ cycles, IRQ=0x80, irq=1; then I2C writes 0x80 to IRQ → IRQ=0x00, irq=0.
- hw_req=2'b11 held continuously, hw_sel=0, data 0x11/0x22 → grants alternate 01,10,01,…; STATUS tracks the last granted data.
- i2c_wr_strobe on the same cycle as hw_req[0] (IRQ set 0x04) → hw_gnt=0 that cycle, grant on the next cycle, IRQ[2]=1; an I2C write of 0x07 to IRQ coincident with a timeout → IRQ[7] stays set.
- rst_n pulsed low during REQ → cfg_req=0, commit_busy=0, all registers 0 asynchronously.

Source files
------------

// File: rtl/serdesphy_csr_ctrl_if.sv
// rtl/serdesphy_csr_ctrl_if.sv - I2C write / hardware requester / register read bundle
interface serdesphy_csr_ctrl_if #(
   parameter int NUM_HW = 2
);
   logic                  i2c_wr_strobe;
   logic [7:0]            i2c_wr_addr;
   logic [7:0]            i2c_wr_data;
   logic [NUM_HW-1:0]     hw_req;
   logic [NUM_HW-1:0]     hw_sel;
   logic [NUM_HW*8-1:0]   hw_data;
   logic [NUM_HW-1:0]     hw_gnt;
   logic [31:0]           regs_rd;

   modport master (
      output i2c_wr_strobe, i2c_wr_addr, i2c_wr_data,
      output hw_req, hw_sel, hw_data,
      input  hw_gnt, regs_rd
   );

   modport slave (
      input  i2c_wr_strobe, i2c_wr_addr, i2c_wr_data,
      input  hw_req, hw_sel, hw_data,
      output hw_gnt, regs_rd
   );
endinterface

// File: rtl/serdesphy_csr_ctrl.sv
// rtl/serdesphy_csr_ctrl.sv - SerDes PHY CSR register file, write arbiter and config commit FSM
module serdesphy_csr_ctrl #(
   parameter int NUM_HW        = 2,
   parameter int APPLY_TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rst_n,
   serdesphy_csr_ctrl_if.slave bus,
   input  logic                i_cfg_ack,
   output logic [7:0]          o_cfg_active,
   output logic                o_cfg_req,
   output logic                o_commit_busy,
   output logic                o_irq
);
   localparam int PW = (NUM_HW > 1) ? $clog2(NUM_HW) : 1;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [15:0]       r_cnt;
   logic [15:0]       w_cnt_nxt;
   logic [7:1]        r_ctrl;
   logic [7:0]        r_cfg;
   logic [7:0]        r_status;
   logic [7:0]        r_irq;
   logic [7:0]        r_cfg_active;
   logic              r_cfg_req;
   logic [PW-1:0]     r_rr;

   logic              w_gvalid;
   logic [PW-1:0]     w_gidx;
   logic [NUM_HW-1:0] w_gnt;
   logic [7:0]        w_hw_data;
   logic              w_hw_sel;
   logic              w_wr_ctrl;
   logic              w_wr_cfg;
   logic              w_wr_irq;
   logic              w_commit;
   logic              w_timeout;
   logic [7:0]        w_set;
   logic [7:0]        w_clr;

   assign w_wr_ctrl = bus.i2c_wr_strobe && (bus.i2c_wr_addr == 8'd0);
   assign w_wr_cfg  = bus.i2c_wr_strobe && (bus.i2c_wr_addr == 8'd1);
   assign w_wr_irq  = bus.i2c_wr_strobe && (bus.i2c_wr_addr == 8'd3);
   assign w_commit  = w_wr_ctrl && bus.i2c_wr_data[0];

   // Ack takes priority over a timeout landing on the same cycle.
   assign w_timeout = (r_state == S_REQ) && !i_cfg_ack &&
                      (r_cnt == 16'(APPLY_TIMEOUT - 1));

   // Round-robin pick among live requests from the pointer; an I2C strobe owns the cycle.
   always_comb begin
      w_gvalid = 1'b0;
      w_gidx   = '0;
      for (int i = 0; i < NUM_HW; i++) begin
         if (!w_gvalid && bus.hw_req[(int'(r_rr) + i) % NUM_HW]) begin
            w_gvalid = 1'b1;
            w_gidx   = PW'((int'(r_rr) + i) % NUM_HW);
         end
      end
      if (bus.i2c_wr_strobe || !rst_n) begin
         w_gvalid = 1'b0;
      end
   end

   // One-hot grant vector from the selected index.
   always_comb begin
      w_gnt = '0;
      if (w_gvalid) begin
         w_gnt[w_gidx] = 1'b1;
      end
   end

   assign w_hw_data = bus.hw_data[int'(w_gidx)*8 +: 8];
   assign w_hw_sel  = bus.hw_sel[w_gidx];

   // Timeout set-bit is independent of arbitration so it can never be blocked.
   assign w_set = ((w_gvalid && w_hw_sel) ? w_hw_data : 8'h00) |
                  (w_timeout ? 8'h80 : 8'h00);
   assign w_clr = w_wr_irq ? bus.i2c_wr_data : 8'h00;

   // Commit FSM next-state and cycle counter.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE: begin
            w_cnt_nxt = '0;
            if (w_commit) begin
               w_state_nxt = S_REQ;
            end
         end
         S_REQ: begin
            if (i_cfg_ack) begin
               w_state_nxt = S_DONE;
            end else if (w_timeout) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_cnt_nxt = r_cnt + 16'd1;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Commit FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Commit request level and active configuration snapshot taken on commit entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cfg_req    <= 1'b0;
         r_cfg_active <= '0;
      end else begin
         r_cfg_req <= (w_state_nxt == S_REQ);
         if ((r_state == S_IDLE) && w_commit) begin
            r_cfg_active <= r_cfg;
         end
      end
   end

   // Register file updates from I2C and granted hardware requesters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ctrl   <= '0;
         r_cfg    <= '0;
         r_status <= '0;
         r_irq    <= '0;
      end else begin
         if (w_wr_ctrl) begin
            r_ctrl <= bus.i2c_wr_data[7:1];
         end
         if (w_wr_cfg) begin
            r_cfg <= bus.i2c_wr_data;
         end
         if (w_gvalid && !w_hw_sel) begin
            r_status <= w_hw_data;
         end
         r_irq <= (r_irq & ~w_clr) | w_set;
      end
   end

   // Round-robin pointer moves past the winner, only when a grant is issued.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr <= '0;
      end else if (w_gvalid) begin
         r_rr <= (int'(w_gidx) == NUM_HW - 1) ? '0 : w_gidx + PW'(1);
      end
   end

   assign o_commit_busy = (r_state != S_IDLE);
   assign o_cfg_req     = r_cfg_req;
   assign o_cfg_active  = r_cfg_active;
   assign o_irq         = |(r_irq & {1'b1, r_ctrl[7:1]});
   assign bus.hw_gnt    = w_gnt;
   assign bus.regs_rd   = {r_irq, o_commit_busy, r_status[6:0], r_cfg, r_ctrl, 1'b0};
endmodule
